// File: rtl/lc_ctrl_pkg.sv
// Shared widths, lifecycle state encodings and FSM state type for the lifecycle
// state holding / transition controller.
package lc_ctrl_pkg;

    function automatic int unsigned vbits(input int unsigned value);
        return (value == 1) ? 1 : $clog2(value);
    endfunction

    localparam int unsigned NumLcStates        = 21;
    localparam int unsigned DataWidth          = 32;
    localparam int unsigned TransCyclesDefault = 4;
    localparam int unsigned StateWidth         = vbits(NumLcStates + 3);
    localparam int unsigned NumRep             = DataWidth / StateWidth;
    localparam int unsigned ExtWidth           = NumRep * StateWidth;

    // Regular states 0..NumLcStates-1 are carried as casts; only the
    // special encodings above the regular range are named.
    typedef enum logic [StateWidth-1:0] {
        LcStFirst = '0,
        PostTrans = StateWidth'(NumLcStates),
        Escalate  = StateWidth'(NumLcStates + 1),
        Invalid   = StateWidth'(NumLcStates + 2)
    } lc_state_e;

    typedef lc_state_e [NumRep-1:0] ext_lc_state_t;

    typedef enum logic [2:0] {
        FsmReset,
        FsmIdle,
        FsmProg,
        FsmDone,
        FsmTerm
    } fsm_state_e;

endpackage

// File: rtl/lc_state_rep_chk.sv
// Combinational replica checker (stored vector XOR fault mask vs. field 0) and
// replicator that spreads one state value across every field.
module lc_state_rep_chk
    import lc_ctrl_pkg::*;
#(
    parameter int unsigned NumRep = lc_ctrl_pkg::NumRep
) (
    input  lc_state_e [NumRep-1:0]            storedState_i,
    input  logic [NumRep*StateWidth-1:0]      faultMask_i,
    input  lc_state_e                         repValue_i,
    output lc_state_e [NumRep-1:0]            repState_o,
    output logic                              mismatch_o
);

    logic [NumRep-1:0][StateWidth-1:0] checked;

    always_comb begin
        checked    = storedState_i ^ faultMask_i;
        mismatch_o = 1'b0;
        for (int i = 1; i < NumRep; i++) begin
            if (checked[i] != checked[0]) begin
                mismatch_o = 1'b1;
            end
        end
        for (int i = 0; i < NumRep; i++) begin
            repState_o[i] = repValue_i;
        end
    end

endmodule

// File: rtl/lc_state_trans_ctrl.sv
// Lifecycle state holder: replicated storage, forward-only timed transitions,
// sticky terminal states on escalation or replica disagreement.
module lc_state_trans_ctrl
    import lc_ctrl_pkg::*;
#(
    parameter int unsigned TransCycles = TransCyclesDefault
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  init_req_i,
    input  logic [StateWidth-1:0] init_state_i,
    input  logic                  trans_req_i,
    input  logic [StateWidth-1:0] trans_target_i,
    input  logic                  escalate_i,
    input  logic [ExtWidth-1:0]   fault_inj_i,
    output logic [StateWidth-1:0] state_o,
    output logic [ExtWidth-1:0]   ext_state_o,
    output logic                  busy_o,
    output logic                  trans_ack_o,
    output logic                  trans_err_o
);

    localparam int unsigned CntWidth = vbits(TransCycles);
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(TransCycles - 1);

    fsm_state_e          fsmQ, fsmD;
    ext_lc_state_t       extQ, extD, repState;
    lc_state_e           curState, repValue;
    logic                writeEn, mismatch, legal;
    logic                ackQ, ackD, errQ, errD;
    logic [CntWidth-1:0] cntQ, cntD;

    assign curState = extQ[0];
    assign legal    = (trans_target_i > curState) &&
                      (trans_target_i < StateWidth'(NumLcStates));

    lc_state_rep_chk #(
        .NumRep(NumRep)
    ) uRepChk (
        .storedState_i(extQ),
        .faultMask_i  (fault_inj_i),
        .repValue_i   (repValue),
        .repState_o   (repState),
        .mismatch_o   (mismatch)
    );

    always_comb begin
        fsmD     = fsmQ;
        cntD     = cntQ;
        repValue = curState;
        writeEn  = 1'b0;
        ackD     = 1'b0;
        errD     = 1'b0;
        // Escalation outranks the replica check, which outranks normal operation.
        if (escalate_i) begin
            fsmD     = FsmTerm;
            repValue = Escalate;
            writeEn  = 1'b1;
        end else if (mismatch) begin
            fsmD     = FsmTerm;
            repValue = Invalid;
            writeEn  = 1'b1;
            errD     = 1'b1;
        end else begin
            case (fsmQ)
                FsmReset: begin
                    if (init_req_i) begin
                        writeEn = 1'b1;
                        if (init_state_i >= StateWidth'(NumLcStates)) begin
                            fsmD     = FsmTerm;
                            repValue = Invalid;
                        end else begin
                            fsmD     = FsmIdle;
                            repValue = lc_state_e'(init_state_i);
                        end
                    end
                end
                FsmIdle: begin
                    if (trans_req_i) begin
                        if (legal) begin
                            fsmD = FsmProg;
                            cntD = '0;
                        end else begin
                            ackD = 1'b1;
                            errD = 1'b1;
                        end
                    end
                end
                FsmProg: begin
                    if (cntQ == CntLast) begin
                        fsmD     = FsmDone;
                        repValue = PostTrans;
                        writeEn  = 1'b1;
                        ackD     = 1'b1;
                    end else begin
                        cntD = cntQ + 1'b1;
                    end
                end
                FsmDone, FsmTerm: ;
                default: begin
                    fsmD     = FsmTerm;
                    repValue = Invalid;
                    writeEn  = 1'b1;
                end
            endcase
        end
    end

    assign extD = writeEn ? repState : extQ;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fsmQ <= FsmReset;
            cntQ <= '0;
            ackQ <= 1'b0;
            errQ <= 1'b0;
            for (int i = 0; i < NumRep; i++) begin
                extQ[i] <= Invalid;
            end
        end else begin
            fsmQ <= fsmD;
            cntQ <= cntD;
            ackQ <= ackD;
            errQ <= errD;
            extQ <= extD;
        end
    end

    assign state_o     = curState;
    assign ext_state_o = extQ;
    assign busy_o      = (fsmQ == FsmProg);
    assign trans_ack_o = ackQ;
    assign trans_err_o = errQ;

endmodule

// File: tb/tb_lc_state_trans_ctrl.sv
// Directed bench: stimulus pushes expected ack/err responses into a queue that a
// negedge monitor drains; timing and state values are also checked in-line.
module tb_lc_state_trans_ctrl;
    import lc_ctrl_pkg::*;

    typedef struct packed {
        logic                  ack;
        logic                  err;
        logic [StateWidth-1:0] st;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  initReq = 1'b0;
    logic [StateWidth-1:0] initState = '0;
    logic                  transReq = 1'b0;
    logic [StateWidth-1:0] transTarget = '0;
    logic                  escalate = 1'b0;
    logic [ExtWidth-1:0]   faultInj = '0;
    logic [StateWidth-1:0] stateOut;
    logic [ExtWidth-1:0]   extOut;
    logic                  busy, ack, err;

    int   checks = 0;
    int   passed = 0;
    exp_t expQ[$];

    lc_state_trans_ctrl #(
        .TransCycles(4)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .init_req_i    (initReq),
        .init_state_i  (initState),
        .trans_req_i   (transReq),
        .trans_target_i(transTarget),
        .escalate_i    (escalate),
        .fault_inj_i   (faultInj),
        .state_o       (stateOut),
        .ext_state_o   (extOut),
        .busy_o        (busy),
        .trans_ack_o   (ack),
        .trans_err_o   (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    function automatic logic [ExtWidth-1:0] rep(input logic [StateWidth-1:0] v);
        logic [ExtWidth-1:0] r;
        for (int i = 0; i < NumRep; i++) r[i*StateWidth +: StateWidth] = v;
        return r;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    task automatic doInit(input logic [StateWidth-1:0] v);
        initReq   = 1'b1;
        initState = v;
        step(1);
        initReq = 1'b0;
    endtask

    task automatic request(input logic [StateWidth-1:0] t);
        transReq    = 1'b1;
        transTarget = t;
        step(1);
        transReq = 1'b0;
    endtask

    // Monitor: every ack/err pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (ack || err) begin
            if (expQ.size() == 0) begin
                checks++;
                $display("FAIL unexpected_pulse: got ack=%0b err=%0b state=%0d, required no pulse",
                         ack, err, stateOut);
            end else begin
                e = expQ.pop_front();
                chk("pulse_ack", 64'(ack), 64'(e.ack));
                chk("pulse_err", 64'(err), 64'(e.err));
                chk("pulse_state", 64'(stateOut), 64'(e.st));
            end
        end
    end

    initial begin
        // Reset state and init to 3
        doReset();
        chk("reset_state", 64'(stateOut), 64'd23);
        chk("reset_ext", 64'(extOut), 64'(rep(5'd23)));
        chk("reset_busy", 64'(busy), 64'd0);
        doInit(5'd3);
        chk("init_state", 64'(stateOut), 64'd3);
        chk("init_ext", 64'(extOut), 64'h06318C63);
        chk("init_busy", 64'(busy), 64'd0);

        // Legal transition 3 -> 10, ack 5 cycles after the request cycle
        expQ.push_back('{ack: 1'b1, err: 1'b0, st: 5'd21});
        request(5'd10);
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("prog_busy_%0d", i), 64'(busy), 64'd1);
            chk($sformatf("prog_noack_%0d", i), 64'(ack), 64'd0);
            step(1);
        end
        chk("done_ack", 64'(ack), 64'd1);
        chk("done_err", 64'(err), 64'd0);
        chk("done_state", 64'(stateOut), 64'd21);
        chk("done_busy", 64'(busy), 64'd0);
        chk("done_ext", 64'(extOut), 64'(rep(5'd21)));
        request(5'd15);
        step(3);
        chk("done_holds", 64'(stateOut), 64'd21);

        // Illegal requests from 10: backwards and same-state
        doReset();
        doInit(5'd10);
        expQ.push_back('{ack: 1'b1, err: 1'b1, st: 5'd10});
        request(5'd5);
        chk("illegal_back_ack", 64'(ack), 64'd1);
        chk("illegal_back_err", 64'(err), 64'd1);
        step(1);
        expQ.push_back('{ack: 1'b1, err: 1'b1, st: 5'd10});
        request(5'd10);
        chk("illegal_same_ack", 64'(ack), 64'd1);
        chk("illegal_same_err", 64'(err), 64'd1);
        step(1);
        chk("illegal_state", 64'(stateOut), 64'd10);
        chk("illegal_busy", 64'(busy), 64'd0);

        // Escalation during Prog cycle 2
        doReset();
        doInit(5'd3);
        request(5'd10);
        step(1);
        escalate = 1'b1;
        step(1);
        escalate = 1'b0;
        chk("esc_state", 64'(stateOut), 64'd22);
        chk("esc_ext", 64'(extOut), 64'(rep(5'd22)));
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("esc_hold_%0d", i), 64'(stateOut), 64'd22);
            chk($sformatf("esc_busy_%0d", i), 64'(busy), 64'd0);
            step(1);
        end

        // Replica fault in Idle
        doReset();
        doInit(5'd3);
        expQ.push_back('{ack: 1'b0, err: 1'b1, st: 5'd23});
        faultInj = 30'h00000020;
        step(1);
        faultInj = '0;
        chk("fault_state", 64'(stateOut), 64'd23);
        chk("fault_ext", 64'(extOut), 64'(rep(5'd23)));
        chk("fault_err", 64'(err), 64'd1);
        chk("fault_ack", 64'(ack), 64'd0);
        step(1);
        chk("fault_err_once", 64'(err), 64'd0);
        doReset();
        chk("fault_reset_ext", 64'(extOut), 64'(rep(5'd23)));
        doInit(5'd5);
        chk("fault_reset_reinit", 64'(stateOut), 64'd5);

        // Escalation and fault together: escalate wins, no err pulse
        doReset();
        doInit(5'd3);
        escalate = 1'b1;
        faultInj = 30'h00000020;
        step(1);
        escalate = 1'b0;
        faultInj = '0;
        chk("escfault_state", 64'(stateOut), 64'd22);
        chk("escfault_err", 64'(err), 64'd0);
        step(2);

        // Out-of-range init goes straight to Term with Invalid
        doReset();
        doInit(5'd25);
        chk("badinit_state", 64'(stateOut), 64'd23);
        chk("badinit_ext", 64'(extOut), 64'(rep(5'd23)));
        request(5'd22);
        step(6);
        chk("badinit_term", 64'(stateOut), 64'd23);
        chk("badinit_busy", 64'(busy), 64'd0);

        step(2);
        chk("queue_drained", 64'(expQ.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
